aes_rcon_seq: RTL and testbench
===============================

Name: aes_rcon_seq

Overview:
Parametrised round-constant sequencer for the AES key expansion. It generates the rcon sequence in GF(2^WIDTH), one value per `next` strobe. It supports the AES-128, AES-192 and AES-256 sequence lengths and both forward and reverse order. Reverse order serves on-the-fly decryption key scheduling and is reached by an internal forward pre-roll after `init`. It sits between the key-memory controller and the key-expansion datapath.

Parameters:
WIDTH, 8, field/output width in bits
POLY, 8'h1b, low WIDTH bits of the reduction polynomial; bit 0 must be 1
INIT, 8'h01, first rcon value of the forward sequence
N128, 10, number of rcon values for mode 2'b00 (also used for 2'b11)
N192, 8, number of rcon values for mode 2'b01
N256, 7, number of rcon values for mode 2'b10
CNT_W, 4, round index width; must satisfy 2^CNT_W > max(N*)

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
init  in  1  single-cycle strobe: start a new sequence, latches mode and dir
mode  in  2  00=128, 01=192, 10=256, 11=treated as 00
dir  in  1  0=forward (INIT upward), 1=reverse (final value down to INIT)
next  in  1  single-cycle strobe: advance to the next rcon value
rcon  out  WIDTH  current round constant
round  out  CNT_W  1-based index of the current rcon in the forward sequence
valid  out  1  rcon/round hold a legal sequence value
last  out  1  current value is the final one for the chosen direction
busy  out  1  pre-roll in progress; next is ignored

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rcon=0, round=0, valid=0, last=0, busy=0, latched mode/dir=0.
- Operations:
  - xtime(x) = {x[W-2:0],1'b0} ^ (POLY & {W{x[W-1]}}).
  - inv_xtime(x) = x[0] ? (((x ^ POLY) >> 1) | MSB) : (x >> 1).
  - N = N128/N192/N256 selected by the latched mode.
- States: IDLE, PREROLL, ACTIVE.
- init, any state, highest priority:
  - Latch mode/dir; rcon<=INIT; round<=1.
  - If dir=0 or N=1: next state ACTIVE.
  - Otherwise: next state PREROLL.
  - init and next in the same cycle: init wins, next dropped.
- PREROLL:
  - busy=1, valid=0.
  - Each cycle: rcon<=xtime(rcon), round<=round+1.
  - When round becomes N: state=ACTIVE.
  - Occupies exactly N-1 cycles.
  - next ignored. A second init restarts from INIT.
- ACTIVE:
  - valid=1, busy=0.
  - last = (dir=0) ? (round==N) : (round==1).
  - next with last=0: forward rcon<=xtime(rcon), round+1; reverse rcon<=inv_xtime(rcon), round-1.
  - next with last=1: state=IDLE, valid=0, last=0; rcon/round keep their final values.
- IDLE: valid=0, busy=0; next ignored.
- All outputs are registered. Value changes appear the cycle after the strobe edge. valid rises the cycle after init (forward) or the cycle after the final pre-roll cycle (reverse).
- round never wraps; it stays within 1..N.
- mode/dir changes outside init have no effect.
- Reset mid-PREROLL or mid-ACTIVE returns immediately to reset values.

Test Plan:
- Forward AES-128: init mode=00 dir=0, then 10 nexts -> rcon 01,02,04,08,10,20,40,80,1b,36 with round 1..10; last only at 36. Next next -> valid=0, rcon stays 36.
- Reverse AES-256: init mode=10 dir=1 -> busy=1 for 6 cycles, then valid=1 with rcon=40, round=7. Nexts give 20,10,08,04,02,01; last at 01/round 1.
- Reverse AES-192 and mode=11: mode 01 -> busy 7 cycles, first value 80/round 8. Mode 11 reverse -> first value 36/round 10, identical to mode 00.
- Strobe priority: next during PREROLL and in IDLE -> no change. init+next together in ACTIVE at rcon=08 -> rcon=01, round=1, next dropped.
- Reset: reset_n low for 1 ns mid-PREROLL with clk stopped -> rcon=0, round=0, valid=0, busy=0 immediately. After release, forward init -> 01.
- Parameter sweep: WIDTH=4, POLY=4'h3, INIT=1, N128=5 forward -> 1,2,4,8,3. Reverse -> 3,8,4,2,1.

Source files
------------

// File: rtl/aes_rcon_seq.sv
// ---------------------------------------------------------------------------
// aes_rcon_seq
//   Round-constant sequencer for the AES key expansion. It produces the rcon
//   sequence in GF(2^WIDTH) one value per `next` strobe. It supports the
//   AES-128/192/256 sequence lengths in forward or reverse order. Reverse
//   order first walks forward internally (pre-roll) to reach the final value.
//   It then steps backwards with the inverse of xtime.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   init     in   strobe: start a new sequence, latches mode and dir
//   mode     in   00=128, 01=192, 10=256, 11=same as 00
//   dir      in   0=forward, 1=reverse
//   next     in   strobe: advance to the next rcon value
//   rcon     out  current round constant
//   round    out  1-based forward index of rcon
//   valid    out  rcon/round hold a legal sequence value
//   last     out  current value is the final one for the chosen direction
//   busy     out  pre-roll in progress (next ignored)
// ---------------------------------------------------------------------------
module aes_rcon_seq #(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  POLY  = 8'h1b,
  parameter logic [WIDTH-1:0]  INIT  = 8'h01,
  parameter int                N128  = 10,
  parameter int                N192  = 8,
  parameter int                N256  = 7,
  parameter int                CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             init,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             next,
  output logic [WIDTH-1:0] rcon,
  output logic [CNT_W-1:0] round,
  output logic             valid,
  output logic             last,
  output logic             busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PREROLL = 2'd1;
  localparam logic [1:0] S_ACTIVE  = 2'd2;

  localparam logic [WIDTH-1:0] MSB   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] ONE_R = CNT_W'(1);

  // Multiply by x in GF(2^WIDTH).
  function automatic logic [WIDTH-1:0] f_xtime(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], 1'b0} ^ (POLY & {WIDTH{x[WIDTH-1]}});
  endfunction

  // Divide by x. An odd value must have had the reduction applied. POLY has
  // bit 0 set, so XOR-ing it back clears bit 0 and restores the shifted-out MSB.
  function automatic logic [WIDTH-1:0] f_inv_xtime(input logic [WIDTH-1:0] x);
    return x[0] ? (((x ^ POLY) >> 1) | MSB) : (x >> 1);
  endfunction

  function automatic logic [CNT_W-1:0] f_len(input logic [1:0] m);
    case (m)
      2'b01:   return CNT_W'(N192);
      2'b10:   return CNT_W'(N256);
      default: return CNT_W'(N128);
    endcase
  endfunction

  logic [1:0]       r_state;
  logic [1:0]       r_mode;
  logic             r_dir;
  logic [WIDTH-1:0] r_rcon;
  logic [CNT_W-1:0] r_round;
  logic             r_valid;
  logic             r_last;
  logic             r_busy;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_rcon_nxt;
  logic [CNT_W-1:0] w_round_nxt;
  logic             w_valid_nxt;
  logic             w_last_nxt;
  logic             w_busy_nxt;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_len_init;
  logic [CNT_W-1:0] w_round_inc;
  logic [CNT_W-1:0] w_round_dec;

  always_comb begin
    w_len       = f_len(r_mode);
    w_len_init  = f_len(mode);
    w_round_inc = r_round + ONE_R;
    w_round_dec = r_round - ONE_R;

    w_state_nxt = r_state;
    w_rcon_nxt  = r_rcon;
    w_round_nxt = r_round;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_busy_nxt  = r_busy;

    if (init) begin
      // init outranks everything, including a simultaneous next.
      w_rcon_nxt  = INIT;
      w_round_nxt = ONE_R;
      if (!dir || (w_len_init == ONE_R)) begin
        // Sequence starts directly at INIT. Whether round 1 is already the
        // final value depends only on the length. Forward ends at round N.
        // Reverse only lands here when N==1.
        w_state_nxt = S_ACTIVE;
        w_valid_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        w_last_nxt  = (w_len_init == ONE_R);
      end else begin
        w_state_nxt = S_PREROLL;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b1;
        w_last_nxt  = 1'b0;
      end
    end else begin
      case (r_state)
        S_PREROLL: begin
          w_rcon_nxt  = f_xtime(r_rcon);
          w_round_nxt = w_round_inc;
          if (w_round_inc == w_len) begin
            // Pre-roll is reverse-only with N>=2, so arriving at round N is
            // the first reverse value and never the final one.
            w_state_nxt = S_ACTIVE;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            w_last_nxt  = 1'b0;
          end
        end
        S_ACTIVE: begin
          if (next) begin
            if (r_last) begin
              w_state_nxt = S_IDLE;
              w_valid_nxt = 1'b0;
              w_last_nxt  = 1'b0;
            end else if (!r_dir) begin
              w_rcon_nxt  = f_xtime(r_rcon);
              w_round_nxt = w_round_inc;
              w_last_nxt  = (w_round_inc == w_len);
            end else begin
              w_rcon_nxt  = f_inv_xtime(r_rcon);
              w_round_nxt = w_round_dec;
              w_last_nxt  = (w_round_dec == ONE_R);
            end
          end
        end
        S_IDLE: begin
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_mode  <= 2'b00;
      r_dir   <= 1'b0;
      r_rcon  <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      if (init) begin
        r_mode <= mode;
        r_dir  <= dir;
      end
      r_state <= w_state_nxt;
      r_rcon  <= w_rcon_nxt;
      r_round <= w_round_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign rcon  = r_rcon;
  assign round = r_round;
  assign valid = r_valid;
  assign last  = r_last;
  assign busy  = r_busy;

endmodule

// File: tb/tb_aes_rcon_seq.sv
module tb_aes_rcon_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       init, dir, next;
  logic [1:0] mode;
  logic [7:0] rcon;
  logic [3:0] round;
  logic       valid, last, busy;

  logic       init4, dir4, next4;
  logic [1:0] mode4;
  logic [3:0] rcon4;
  logic [3:0] round4;
  logic       valid4, last4, busy4;

  aes_rcon_seq dut (
    .clk(clk), .reset_n(reset_n), .init(init), .mode(mode), .dir(dir),
    .next(next), .rcon(rcon), .round(round), .valid(valid), .last(last),
    .busy(busy)
  );

  aes_rcon_seq #(
    .WIDTH(4), .POLY(4'h3), .INIT(4'h1), .N128(5), .N192(4), .N256(3), .CNT_W(4)
  ) dut4 (
    .clk(clk), .reset_n(reset_n), .init(init4), .mode(mode4), .dir(dir4),
    .next(next4), .rcon(rcon4), .round(round4), .valid(valid4), .last(last4),
    .busy(busy4)
  );

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic       ini;
    logic [1:0] md;
    logic       dr;
    logic       nx;
    logic [7:0] rc;
    logic [3:0] rd;
    logic       v;
    logic       l;
    logic       b;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic ini, input logic [1:0] md, input logic dr,
                              input logic nx, input logic [7:0] rc, input logic [3:0] rd,
                              input logic v, input logic l, input logic b);
    vec_t e;
    e.ini = ini; e.md = md; e.dr = dr; e.nx = nx;
    e.rc = rc; e.rd = rd; e.v = v; e.l = l; e.b = b;
    tbl.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int e_rc, input int e_rd,
                         input int e_v, input int e_l, input int e_b);
    chk({tag, ".rcon"},  32'(rcon),  e_rc);
    chk({tag, ".round"}, 32'(round), e_rd);
    chk({tag, ".valid"}, 32'(valid), e_v);
    chk({tag, ".last"},  32'(last),  e_l);
    chk({tag, ".busy"},  32'(busy),  e_b);
  endtask

  task automatic chk_out4(input string tag, input int e_rc, input int e_rd,
                          input int e_v, input int e_l, input int e_b);
    chk({tag, ".rcon"},  32'(rcon4),  e_rc);
    chk({tag, ".round"}, 32'(round4), e_rd);
    chk({tag, ".valid"}, 32'(valid4), e_v);
    chk({tag, ".last"},  32'(last4),  e_l);
    chk({tag, ".busy"},  32'(busy4),  e_b);
  endtask

  // One clock edge; outputs are sampled 1 ns later and strobes are dropped.
  task automatic tick();
    @(posedge clk);
    #1;
    init = 1'b0; next = 1'b0; init4 = 1'b0; next4 = 1'b0;
  endtask

  // Reverse start: init, expect busy for nbusy cycles with next ignored, then
  // check the first reverse value.
  task automatic rev_start(input string tag, input logic [1:0] md, input int nbusy,
                           input int e_rc, input int e_rd);
    init = 1'b1; mode = md; dir = 1'b1;
    tick();
    for (int c = 0; c < nbusy; c++) begin
      chk($sformatf("%s.busy%0d", tag, c), 32'(busy), 1);
      chk($sformatf("%s.valid%0d", tag, c), 32'(valid), 0);
      next = 1'b1;
      tick();
    end
    chk_out({tag, ".first"}, e_rc, e_rd, 1, 0, 0);
  endtask

  // Reference model: the forward sequence as a table built by doubling with
  // modular reduction; reverse order just reads the table backwards.
  int seq[16];
  int m_ph, m_n, m_dir, m_idx, m_pre;

  function automatic int len_of(input int md);
    case (md)
      1:       return 8;
      2:       return 7;
      default: return 10;
    endcase
  endfunction

  task automatic model_step(input int ini, input int md, input int dr, input int nx);
    if (ini != 0) begin
      m_n = len_of(md); m_dir = dr; m_idx = 1;
      if (dr == 0 || m_n == 1) m_ph = 2;
      else begin m_ph = 1; m_pre = m_n - 1; end
    end else if (m_ph == 1) begin
      m_idx++; m_pre--;
      if (m_pre == 0) m_ph = 2;
    end else if (m_ph == 2 && nx != 0) begin
      if ((m_dir != 0) ? (m_idx == 1) : (m_idx == m_n)) m_ph = 0;
      else m_idx += (m_dir != 0) ? -1 : 1;
    end
  endtask

  int fw[10] = '{'h01, 'h02, 'h04, 'h08, 'h10, 'h20, 'h40, 'h80, 'h1b, 'h36};
  int w4[5]  = '{1, 2, 4, 8, 3};

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    init = 0; dir = 0; next = 0; mode = 0;
    init4 = 0; dir4 = 0; next4 = 0; mode4 = 0;
    @(posedge clk); @(posedge clk); #1;
    chk_out("reset", 0, 0, 0, 0, 0);
    chk_out4("reset4", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();
    chk_out("idle", 0, 0, 0, 0, 0);

    // ---- table-driven vectors ----
    add(1, 2'b00, 0, 0, 8'h01, 4'd1, 1, 0, 0);
    for (int k = 1; k < 10; k++)
      add(0, 2'b00, 0, 1, 8'(fw[k]), 4'(k + 1), 1, (k == 9), 0);
    add(0, 2'b00, 0, 1, 8'h36, 4'd10, 0, 0, 0);   // next on last -> idle
    add(0, 2'b00, 0, 1, 8'h36, 4'd10, 0, 0, 0);   // next in idle ignored
    add(1, 2'b00, 0, 0, 8'h01, 4'd1, 1, 0, 0);
    add(0, 2'b00, 0, 1, 8'h02, 4'd2, 1, 0, 0);
    add(0, 2'b00, 0, 1, 8'h04, 4'd3, 1, 0, 0);
    add(0, 2'b00, 0, 1, 8'h08, 4'd4, 1, 0, 0);
    add(1, 2'b00, 0, 1, 8'h01, 4'd1, 1, 0, 0);    // init+next: init wins
    add(0, 2'b00, 0, 1, 8'h02, 4'd2, 1, 0, 0);
    add(1, 2'b01, 0, 0, 8'h01, 4'd1, 1, 0, 0);    // AES-192 forward
    for (int k = 1; k < 8; k++)
      add(0, 2'b01, 0, 1, 8'(fw[k]), 4'(k + 1), 1, (k == 7), 0);
    add(1, 2'b10, 0, 0, 8'h01, 4'd1, 1, 0, 0);    // AES-256 forward
    for (int k = 1; k < 7; k++)
      add(0, 2'b10, 0, 1, 8'(fw[k]), 4'(k + 1), 1, (k == 6), 0);
    add(0, 2'b10, 0, 1, 8'h40, 4'd7, 0, 0, 0);

    foreach (tbl[i]) begin
      init = tbl[i].ini; mode = tbl[i].md; dir = tbl[i].dr; next = tbl[i].nx;
      tick();
      chk_out($sformatf("vec%0d", i), int'(tbl[i].rc), int'(tbl[i].rd),
              int'(tbl[i].v), int'(tbl[i].l), int'(tbl[i].b));
    end

    // ---- reverse AES-256 ----
    rev_start("rev256", 2'b10, 6, 'h40, 7);
    for (int k = 5; k >= 0; k--) begin
      next = 1'b1;
      tick();
      chk_out($sformatf("rev256.r%0d", k + 1), fw[k], k + 1, 1, (k == 0), 0);
    end
    next = 1'b1;
    tick();
    chk_out("rev256.end", 'h01, 1, 0, 0, 0);

    // ---- reverse AES-192 and mode 11 ----
    rev_start("rev192", 2'b01, 7, 'h80, 8);
    next = 1'b1;
    tick();
    chk_out("rev192.r7", 'h40, 7, 1, 0, 0);
    rev_start("rev11", 2'b11, 9, 'h36, 10);
    next = 1'b1;
    tick();
    chk_out("rev11.r9", 'h1b, 9, 1, 0, 0);
    next = 1'b1;
    tick();
    chk_out("rev11.r8", 'h80, 8, 1, 0, 0);

    // ---- async reset mid pre-roll, no clock edge while low ----
    init = 1'b1; mode = 2'b10; dir = 1'b1;
    tick();
    tick();
    chk("prerst.busy", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1 chk_out("prerst.async", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    init = 1'b1; mode = 2'b00; dir = 1'b0;
    tick();
    chk_out("prerst.fwd", 'h01, 1, 1, 0, 0);

    // ---- 4-bit field instance ----
    init4 = 1'b1; mode4 = 2'b00; dir4 = 1'b0;
    tick();
    chk_out4("w4f.0", 1, 1, 1, 0, 0);
    for (int k = 1; k < 5; k++) begin
      next4 = 1'b1;
      tick();
      chk_out4($sformatf("w4f.%0d", k), w4[k], k + 1, 1, (k == 4), 0);
    end
    init4 = 1'b1; dir4 = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("w4r.busy%0d", c), 32'(busy4), 1);
      tick();
    end
    chk_out4("w4r.first", 3, 5, 1, 0, 0);
    for (int k = 3; k >= 0; k--) begin
      next4 = 1'b1;
      tick();
      chk_out4($sformatf("w4r.%0d", k), w4[k], k + 1, 1, (k == 0), 0);
    end

    // ---- randomized run against the reference model ----
    seq[0] = 0;
    seq[1] = 'h01;
    for (int k = 2; k < 16; k++) begin
      seq[k] = seq[k-1] * 2;
      if (seq[k] > 255) seq[k] = (seq[k] - 256) ^ 'h1b;
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    m_ph = 0; m_n = 10; m_dir = 0; m_idx = 0; m_pre = 0;
    for (int it = 0; it < 400; it++) begin
      init = ($urandom_range(0, 7) == 0);
      mode = 2'($urandom_range(0, 3));
      dir  = 1'($urandom_range(0, 1));
      next = 1'($urandom_range(0, 1));
      model_step(int'(init), int'(mode), int'(dir), int'(next));
      tick();
      chk_out($sformatf("rnd%0d", it), seq[m_idx], m_idx, (m_ph == 2), (m_ph == 2) &&
              ((m_dir != 0) ? (m_idx == 1) : (m_idx == m_n)), (m_ph == 1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
